// File: rtl/bitty_sequencer.sv
// rtl/bitty_sequencer.sv - multi-cycle control FSM for the Bitty core
//
// Latches each 16-bit instruction from the fetch unit and steps the datapath
// through source load, ALU/compare, writeback and data-memory handshake, then
// pulses done/en_pc once per instruction. A watchdog aborts a data-memory
// access that is not acknowledged within TIMEOUT cycles and sets sticky err.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   run          in   level; allows instruction issue (sampled in IDLE/DONE)
//   instruction  in   16-bit instruction word, valid during FETCH
//   mem_ack      in   data-memory completion, sampled in MEM
//   en_i         out  instruction-register load
//   en_s         out  S register load
//   en_c         out  C register load
//   sel_mux      out  source select: 0-7 R0-R7, 8 imm, 9 mem data, 10 C
//   alu_sel      out  ALU op; 7 = compare
//   en_reg       out  one-hot register-file write enable
//   mem_req      out  data-memory request
//   mem_we       out  1 = store, valid with mem_req
//   done         out  one-cycle instruction-complete pulse
//   en_pc        out  PC update enable, coincident with done
//   err          out  sticky memory-timeout flag

module bitty_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] instruction,
    input  logic        mem_ack,
    output logic        en_i,
    output logic        en_s,
    output logic        en_c,
    output logic [3:0]  sel_mux,
    output logic [2:0]  alu_sel,
    output logic [7:0]  en_reg,
    output logic        mem_req,
    output logic        mem_we,
    output logic        done,
    output logic        en_pc,
    output logic        err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] FMT_REG    = 2'b00;
    localparam logic [1:0] FMT_IMM    = 2'b01;
    localparam logic [1:0] FMT_BRANCH = 2'b10;
    localparam logic [1:0] FMT_MEM    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EX1,
        S_EX2,
        S_WB,
        S_MEM,
        S_MEMWB,
        S_DONE
    } state_t;

    state_t          state;
    logic [15:0]     ir;
    logic [CW-1:0]   cnt;

    logic [2:0] rx;
    logic [2:0] ry;
    logic [2:0] alu;
    logic [1:0] fmt;
    logic       is_store;

    assign rx       = ir[15:13];
    assign ry       = ir[12:10];
    assign alu      = ir[4:2];
    assign fmt      = ir[1:0];
    assign is_store = ir[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            ir    <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    ir    <= instruction;
                    state <= S_EX1;
                end
                S_EX1: begin
                    state <= (fmt == FMT_MEM) ? S_MEM : S_EX2;
                end
                S_EX2: begin
                    state <= (fmt == FMT_BRANCH) ? S_DONE : S_WB;
                end
                S_WB: begin
                    state <= S_DONE;
                end
                S_MEM: begin
                    // An ack arriving on the last allowed cycle still wins.
                    if (mem_ack) begin
                        cnt   <= '0;
                        state <= is_store ? S_DONE : S_MEMWB;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_MEMWB: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= run ? S_FETCH : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode from the registered state, so reset clears every enable
    // (including mem_req) as soon as the state register is forced to IDLE.
    always_comb begin
        en_i    = 1'b0;
        en_s    = 1'b0;
        en_c    = 1'b0;
        sel_mux = 4'd0;
        alu_sel = 3'd0;
        en_reg  = 8'h00;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        done    = 1'b0;
        en_pc   = 1'b0;
        case (state)
            S_FETCH: begin
                en_i = 1'b1;
            end
            S_EX1: begin
                sel_mux = {1'b0, rx};
                en_s    = 1'b1;
            end
            S_EX2: begin
                en_c = 1'b1;
                case (fmt)
                    FMT_REG: begin
                        sel_mux = {1'b0, ry};
                        alu_sel = alu;
                    end
                    FMT_IMM: begin
                        sel_mux = 4'd8;
                        alu_sel = alu;
                    end
                    FMT_BRANCH: begin
                        sel_mux = {1'b0, ry};
                        alu_sel = 3'd7;
                    end
                    default: begin
                        en_c = 1'b0;
                    end
                endcase
            end
            S_WB: begin
                sel_mux = 4'd10;
                en_reg  = 8'h01 << rx;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
            end
            S_MEMWB: begin
                sel_mux = 4'd9;
                en_reg  = 8'h01 << rx;
            end
            S_DONE: begin
                done  = 1'b1;
                en_pc = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bitty_sequencer.sv
// tb/tb_bitty_sequencer.sv - self-checking bench for bitty_sequencer

module tb_bitty_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] instruction;
    logic        mem_ack;
    logic        en_i;
    logic        en_s;
    logic        en_c;
    logic [3:0]  sel_mux;
    logic [2:0]  alu_sel;
    logic [7:0]  en_reg;
    logic        mem_req;
    logic        mem_we;
    logic        done;
    logic        en_pc;
    logic        err;

    bitty_sequencer #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instruction (instruction),
        .mem_ack     (mem_ack),
        .en_i        (en_i),
        .en_s        (en_s),
        .en_c        (en_c),
        .sel_mux     (sel_mux),
        .alu_sel     (alu_sel),
        .en_reg      (en_reg),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .done        (done),
        .en_pc       (en_pc),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       en_i;
        logic       en_s;
        logic       en_c;
        logic [3:0] sel;
        logic [2:0] alu;
        logic [7:0] en_reg;
        logic       mem_req;
        logic       mem_we;
        logic       done;
        logic       en_pc;
        logic       err;
    } outs_t;

    typedef struct {
        logic        run;
        logic [15:0] instr;
        logic        ack;
        outs_t       exp;
        string       name;
    } vec_t;

    outs_t act;
    assign act = {en_i, en_s, en_c, sel_mux, alu_sel, en_reg,
                  mem_req, mem_we, done, en_pc, err};

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];

    function automatic outs_t o_z();
        outs_t o = '0;
        return o;
    endfunction

    function automatic outs_t o_fetch();
        outs_t o = '0;
        o.en_i = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_ex1(input logic [3:0] s);
        outs_t o = '0;
        o.en_s = 1'b1;
        o.sel  = s;
        return o;
    endfunction

    function automatic outs_t o_ex2(input logic [3:0] s, input logic [2:0] a);
        outs_t o = '0;
        o.en_c = 1'b1;
        o.sel  = s;
        o.alu  = a;
        return o;
    endfunction

    function automatic outs_t o_wb(input logic [3:0] s, input logic [7:0] r);
        outs_t o = '0;
        o.sel    = s;
        o.en_reg = r;
        return o;
    endfunction

    function automatic outs_t o_mem(input logic we);
        outs_t o = '0;
        o.mem_req = 1'b1;
        o.mem_we  = we;
        return o;
    endfunction

    function automatic outs_t o_done();
        outs_t o = '0;
        o.done  = 1'b1;
        o.en_pc = 1'b1;
        return o;
    endfunction

    task automatic add(input logic r, input logic [15:0] i, input logic a,
                       input outs_t e, input string nm);
        vec_t v;
        v.run = r; v.instr = i; v.ack = a; v.exp = e; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic chk_outs(input string nm, input outs_t e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %06h expected %06h", nm, act, e);
        end
    endtask

    task automatic chk_val(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;
    int wb_seen;
    outs_t e;

    initial begin
        reset       = 1'b0;
        run         = 1'b0;
        instruction = 16'h0000;
        mem_ack     = 1'b0;
        #1;
        chk_outs("reset_state", o_z());
        #11;
        reset = 1'b1;
        @(negedge clk);
        tick();

        // ALU reg 2400 back-to-back into immediate 4005 (run low mid-instruction)
        add(1, 16'h0000, 0, o_z(),                "idle_issue");
        add(1, 16'h2400, 0, o_fetch(),            "alu_fetch");
        add(1, 16'h0000, 0, o_ex1(4'd1),          "alu_ex1");
        add(1, 16'h0000, 0, o_ex2(4'd1, 3'd0),    "alu_ex2");
        add(1, 16'h0000, 1, o_wb(4'd10, 8'h02),   "alu_wb");
        add(1, 16'h0000, 0, o_done(),             "alu_done");
        add(1, 16'h4005, 0, o_fetch(),            "imm_fetch");
        add(0, 16'h0000, 0, o_ex1(4'd2),          "imm_ex1");
        add(0, 16'h0000, 0, o_ex2(4'd8, 3'd1),    "imm_ex2");
        add(0, 16'h0000, 0, o_wb(4'd10, 8'h04),   "imm_wb");
        add(1, 16'h0000, 0, o_done(),             "imm_done");
        // branch 0002
        add(1, 16'h0002, 0, o_fetch(),            "br_fetch");
        add(1, 16'h0000, 0, o_ex1(4'd0),          "br_ex1");
        add(1, 16'h0000, 0, o_ex2(4'd0, 3'd7),    "br_ex2");
        add(1, 16'h0000, 0, o_done(),             "br_done");
        // load E003, ack on third MEM cycle
        add(1, 16'hE003, 0, o_fetch(),            "ld_fetch");
        add(1, 16'h0000, 0, o_ex1(4'd7),          "ld_ex1");
        add(1, 16'h0000, 0, o_mem(1'b0),          "ld_mem1");
        add(1, 16'h0000, 0, o_mem(1'b0),          "ld_mem2");
        add(1, 16'h0000, 1, o_mem(1'b0),          "ld_mem3");
        add(1, 16'h0000, 0, o_wb(4'd9, 8'h80),    "ld_memwb");
        add(0, 16'h0000, 0, o_done(),             "ld_done");
        add(0, 16'h0000, 1, o_z(),                "idle_ack_ignored");
        add(1, 16'h0000, 0, o_z(),                "idle_hold");
        // store 0007, ack on first MEM cycle
        add(1, 16'h0007, 0, o_fetch(),            "st_fetch");
        add(1, 16'h0000, 0, o_ex1(4'd0),          "st_ex1");
        add(1, 16'h0000, 1, o_mem(1'b1),          "st_mem");
        add(0, 16'h0000, 0, o_done(),             "st_done");
        add(0, 16'h0000, 0, o_z(),                "st_idle");

        // idle_hold uses run=1 only to issue the store; row order matters.
        for (int i = 0; i < tbl.size(); i++) begin
            run         = tbl[i].run;
            instruction = tbl[i].instr;
            mem_ack     = tbl[i].ack;
            chk_outs(tbl[i].name, tbl[i].exp);
            tick();
        end
        mem_ack = 1'b0;
        run     = 1'b0;

        // Store with no ack: 16 MEM cycles, then err and an abort DONE.
        run = 1'b1;
        instruction = 16'h0007;
        tick();                       // FETCH
        tick();                       // EX1
        tick();                       // first MEM
        n = 0;
        wb_seen = 0;
        while (mem_req && n < 40) begin
            n++;
            if (en_reg != 8'h00) wb_seen = 1;
            tick();
        end
        chk_val("timeout_mem_cycles", n, 16);
        e = o_done();
        e.err = 1'b1;
        chk_outs("timeout_done", e);
        chk_val("timeout_no_wb", wb_seen, 0);

        // err persists across a following branch
        instruction = 16'h0002;
        tick();                       // FETCH
        run = 1'b0;
        tick();                       // EX1
        tick();                       // EX2
        tick();                       // DONE
        e = o_done();
        e.err = 1'b1;
        chk_outs("err_sticky_done", e);
        tick();                       // IDLE
        chk_val("err_sticky_idle", err, 1);

        // Reset mid-WB with run high
        run = 1'b1;
        instruction = 16'h2400;
        tick();                       // FETCH
        tick();                       // EX1
        tick();                       // EX2
        tick();                       // WB
        chk_val("wb_before_reset", en_reg, 8'h02);
        #2;
        reset = 1'b0;
        #1;
        chk_outs("reset_mid_wb", o_z());
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_outs("after_release_idle", o_z());
        @(posedge clk);
        #1;
        chk_outs("after_release_fetch", o_fetch());
        run = 1'b0;
        tick();                       // EX1
        tick();                       // EX2
        tick();                       // WB
        tick();                       // DONE
        tick();                       // IDLE

        // Ack on the very cycle the watchdog would fire: ack wins.
        run = 1'b1;
        instruction = 16'h0007;
        tick();                       // FETCH
        tick();                       // EX1
        tick();                       // MEM cycle 1
        run = 1'b0;
        n = 0;
        while (mem_req && n < 15) begin
            n++;
            tick();
        end
        chk_val("late_ack_cycles", n, 15);
        chk_val("late_ack_still_mem", mem_req, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk_outs("late_ack_done", o_done());
        tick();
        chk_outs("late_ack_idle", o_z());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bitty_sequencer.md
# bitty_sequencer

Multi-cycle control FSM for the Bitty core. It latches each 16-bit instruction presented by the fetch unit and walks the datapath through its steps: source load, ALU/compare, register writeback, data-memory handshake. It then pulses `done` and `en_pc` so the fetch unit's branch logic and PC advance exactly once per instruction. It is the only producer of datapath enables; a mem-ack watchdog keeps a dead data memory from hanging the core.

## Interface
- `TIMEOUT`, 16: max cycles `mem_req` may wait for `mem_ack` before abort (≥1).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; low forces the reset state immediately.
- `run` in 1: level; high allows instruction issue, sampled in IDLE and DONE.
- `instruction` in 16: fetch-unit memory output, valid during FETCH.
- `mem_ack` in 1: data-memory completion, sampled in MEM.
- `en_i` out 1: instruction-register load.
- `en_s` out 1: S register load.
- `en_c` out 1: C register load.
- `sel_mux` out 4: 0–7 = R0–R7, 8 = immediate, 9 = memory data, 10 = C register.
- `alu_sel` out 3: ALU op; 3'd7 = compare.
- `en_reg` out 8: one-hot register-file write enable.
- `mem_req` out 1: data-memory request.
- `mem_we` out 1: 1 = store, valid while `mem_req`.
- `done` out 1: one-cycle instruction-complete pulse to branch logic.
- `en_pc` out 1: PC update enable, asserted with `done`.
- `err` out 1: sticky mem-timeout flag.

## Operation
- Internal `ir` is latched from `instruction` in FETCH. Fields: Rx=`ir[15:13]`, Ry=`ir[12:10]`, alu=`ir[4:2]`, fmt=`ir[1:0]`, store bit=`ir[2]`.
- fmt values: 00 = reg ALU, 01 = immediate ALU, 10 = branch, 11 = load/store.
- States: IDLE, FETCH, EX1, EX2, WB, MEM, MEMWB, DONE. Outputs are Moore, decoded from state and `ir`. Unlisted outputs are 0.
- IDLE: `run`=1 -> FETCH.
- FETCH: `en_i`=1 -> EX1.
- EX1: `sel_mux`=Rx, `en_s`=1. fmt 11 -> MEM; otherwise -> EX2.
- EX2 by fmt:
  - 00: `sel_mux`=Ry, `alu_sel`=alu, `en_c`=1 -> WB.
  - 01: `sel_mux`=8, `alu_sel`=alu, `en_c`=1 -> WB.
  - 10: `sel_mux`=Ry, `alu_sel`=7, `en_c`=1 -> DONE.
- WB: `sel_mux`=10, `en_reg`=1<<Rx -> DONE.
- MEM: `mem_req`=1, `mem_we`=`ir[2]`; timeout counter increments each MEM cycle.
  - `mem_ack`=1: load -> MEMWB; store -> DONE.
  - Counter reaches TIMEOUT-1 without ack: `err`<=1 -> DONE, no writeback.
  - Counter clears on leaving MEM.
- MEMWB: `sel_mux`=9, `en_reg`=1<<Rx -> DONE.
- DONE: `done`=1, `en_pc`=1. `run`=1 -> FETCH, else IDLE.
- `err` clears only on reset.
- Register writes use one-hot `en_reg`; never more than one bit is set. R0 is writable, with no special casing.

## Timing
- Reset (async, low): state=IDLE, `ir`=0, counter=0, `err`=0, all outputs 0, including `mem_req`. Reset mid-MEM drops `mem_req` in the same cycle, asynchronously.
- Instruction latency from FETCH to DONE, inclusive:
  - ALU reg/imm: 5 cycles.
  - Branch: 4 cycles.
  - Store: 3 + wait cycles.
  - Load: 4 + wait cycles.
  - Wait = cycles in MEM before ack, minimum 1.
- Back-to-back issue: with `run` held high, DONE is followed directly by FETCH, with no IDLE bubble.
- `mem_ack` in the same cycle as the timeout: the ack wins and `err` stays 0.
- `mem_ack` outside MEM is ignored.
- `run` falling mid-instruction: the instruction completes, then the FSM returns to IDLE.
- `done` and `en_pc` are always coincident, exactly one cycle per instruction. This includes timeout aborts.

## Test plan
- Reset low mid-WB, `run`=1 -> all outputs 0 immediately; after release, IDLE -> FETCH on the next edge.
- Instruction 16'h2400 (ALU, Rx=1, Ry=1, alu=0), `run` held -> `en_i`, `en_s` (sel 1), `en_c` (sel 1, alu 0), `en_reg`=8'h02 (sel 10), `done`+`en_pc` on cycles 1–5; FETCH is on cycle 6.
- Immediate 16'h4005 (Rx=2, fmt 01, alu=1) -> EX2 `sel_mux`=8, `alu_sel`=1; WB `en_reg`=8'h04.
- Branch 16'h0002 -> EX2 `alu_sel`=7, `en_c`=1; `done` on cycle 4 with no `en_reg` pulse.
- Load 16'hE003 (Rx=7) with `mem_ack` after 3 MEM cycles -> `mem_req`=1 and `mem_we`=0 for 3 cycles, MEMWB `en_reg`=8'h80 with `sel_mux`=9, then `done`.
- Store 16'h0007 with `mem_ack` never asserted, TIMEOUT=16 -> `mem_req` high for 16 cycles, then `err`=1 and `done` with no writeback. `err` stays high across later instructions until reset.
